instruction_loader: RTL
=======================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter BIT_WIDTH_EXTERNAL_PORT, default 32, SHALL set the stream and instruction-memory write data/address width.
REQ-002 Parameter INSTRUCTION_MEMORY_SIZE, default 32, SHALL set the number of layer slots.
REQ-003 Parameter INSTRUCTION_MEMORY_FIELDS, default 24, SHALL set the number of fields per layer.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a one-cycle request to begin a load; honoured only in IDLE.
REQ-007 s_valid  input  1  SHALL mark s_data as valid.
REQ-008 s_data  input  BIT_WIDTH_EXTERNAL_PORT  SHALL carry the header, field words and (optional) checksum.
REQ-009 s_ready  output  1  SHALL signal word acceptance; a word transfers when s_valid and s_ready are both high.
REQ-010 wr_en_ext_im  output  1  SHALL be the instruction-memory write strobe.
REQ-011 wr_addr_ext_im  output  BIT_WIDTH_EXTERNAL_PORT  SHALL be the write address: {layer, field}, field in the low clog2(INSTRUCTION_MEMORY_FIELDS) bits.
REQ-012 wr_data_ext_im  output  BIT_WIDTH_EXTERNAL_PORT  SHALL be the write data.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done  output  1  SHALL pulse for one cycle when a load ends, successfully or not.
REQ-015 error  output  1  SHALL flag the failure of the last load; held until the next start.

Function
REQ-016 States SHALL be IDLE, HEADER, LOAD, CHECK, DONE.
REQ-017 IDLE->HEADER on start; s_ready SHALL be low in IDLE and DONE.
REQ-018 Header word SHALL be [15:0] = layer count N, [31:16] = first layer L; the state SHALL leave HEADER on header acceptance.
REQ-019 A header with N = 0 or L+N > INSTRUCTION_MEMORY_SIZE SHALL set error and go HEADER->DONE with no writes.
REQ-020 A valid header SHALL go HEADER->LOAD; field counter f=0, layer counter l=L.
REQ-021 In LOAD each accepted word SHALL produce exactly one write, exactly one cycle later, with wr_addr = {l, f} and wr_data = that word.
REQ-022 f SHALL wrap from INSTRUCTION_MEMORY_FIELDS-1 to 0 and increment l; after N*INSTRUCTION_MEMORY_FIELDS words the state SHALL leave LOAD (to CHECK or DONE per REQ-029/030).
REQ-023 s_ready SHALL be high continuously in HEADER, LOAD and CHECK (no backpressure); s_valid low stalls counters with no write.
REQ-024 wr_en_ext_im SHALL be high only in the cycle after a LOAD handshake; wr_addr/wr_data SHALL hold their last values otherwise.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE the next cycle.
REQ-026 start outside IDLE SHALL be ignored; start SHALL clear error on entering HEADER.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, s_ready=0, wr_en_ext_im=0, wr_addr_ext_im=0, wr_data_ext_im=0, busy=0, done=0, error=0, counters=0.
REQ-028 Reset mid-load SHALL abandon the load without any further write or done pulse; already written entries are not reverted.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined: after the last field word, LOAD->CHECK; the next accepted word SHALL be compared with the XOR of all field words; mismatch SHALL set error; CHECK->DONE.
REQ-030 Without LOADER_CHECKSUM_EN: LOAD->DONE directly after the last field word; no CHECK state logic; error only from REQ-019.

Verification
REQ-031 start, header 0x0002_0001 (L=2,N=1), 24 words 0x100..0x117 back-to-back -> 24 writes, addr {2,0}..{2,23} = 0x40..0x57, data 0x100..0x117, done once, error=0.
REQ-032 Header L=31, N=2 -> no write, done pulse two cycles after header handshake, error=1; next start clears error.
REQ-033 N=2, L=0, s_valid toggling every cycle -> 48 writes, field wraps 23->0 with layer 0->1 (addr 0x17 then 0x20), no gaps.
REQ-034 reset low after 10 of 24 words -> exactly 10 writes seen, all outputs 0 while reset low, no done pulse.
REQ-035 LOADER_CHECKSUM_EN, N=1, words 0x1..0x18, checksum 0x18 -> error=0; checksum 0x19 -> error=1.
REQ-036 start pulsed during LOAD -> ignored, load completes unchanged.

Source files
------------

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Purpose:
//   Receives a header word and a stream of instruction field words, then
//   writes the field words into the external instruction memory. The header
//   selects the first layer slot L (bits [31:16]) and the layer count N
//   (bits [15:0]). Each layer is INSTRUCTION_MEMORY_FIELDS words long. The
//   write address is {layer, field}, with the field index in the low
//   clog2(INSTRUCTION_MEMORY_FIELDS) bits.
//
// Configuration macro:
//   LOADER_CHECKSUM_EN - when defined, one more stream word follows the last
//   field word. That word must equal the XOR of all field words. A mismatch
//   raises error.
//
// Ports:
//   clk             in   single clock, rising edge
//   reset           in   asynchronous active-low reset
//   start           in   one-cycle load request, honoured only in IDLE
//   s_valid         in   stream word valid
//   s_data          in   stream word (header / field / checksum)
//   s_ready         out  stream ready; high in HEADER, LOAD and CHECK
//   wr_en_ext_im    out  instruction-memory write strobe
//   wr_addr_ext_im  out  instruction-memory write address {layer, field}
//   wr_data_ext_im  out  instruction-memory write data
//   busy            out  high whenever the FSM is not in IDLE
//   done            out  one-cycle pulse when a load ends
//   error           out  failure flag of the last load, held until next start
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int BIT_WIDTH_EXTERNAL_PORT   = 32,
    parameter int INSTRUCTION_MEMORY_SIZE   = 32,
    parameter int INSTRUCTION_MEMORY_FIELDS = 24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               s_valid,
    input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0] s_data,
    output logic                               s_ready,
    output logic                               wr_en_ext_im,
    output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] wr_addr_ext_im,
    output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] wr_data_ext_im,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam int W  = BIT_WIDTH_EXTERNAL_PORT;
    localparam int FW = (INSTRUCTION_MEMORY_FIELDS > 1) ? $clog2(INSTRUCTION_MEMORY_FIELDS) : 1;
    localparam int LW = (INSTRUCTION_MEMORY_SIZE > 1) ? $clog2(INSTRUCTION_MEMORY_SIZE) : 1;

    localparam logic [FW-1:0] FIELD_LAST = FW'(INSTRUCTION_MEMORY_FIELDS - 1);
    localparam logic [16:0]   MEM_SIZE   = 17'(INSTRUCTION_MEMORY_SIZE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Packs {layer, field} into a zero-extended memory address.
    function automatic logic [W-1:0] make_addr(input logic [15:0]   layer,
                                               input logic [FW-1:0] field);
        logic [W-1:0] a;
        a            = {W{1'b0}};
        a[FW-1:0]    = field;
        a[FW+:LW]    = layer[LW-1:0];
        return a;
    endfunction

    state_t         state_q, state_d;
    logic [FW-1:0]  f_q, f_d;          // field index within the current layer
    logic [15:0]    l_q, l_d;          // current layer slot
    logic [15:0]    rem_q, rem_d;      // layers still to be loaded, current one included
    logic           s_ready_q, s_ready_d;
    logic           wr_en_q, wr_en_d;
    logic [W-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0]   csum_q, csum_d;    // running XOR of the field words
`endif

    logic           hs_s;
    logic [15:0]    hdr_n_s;
    logic [15:0]    hdr_l_s;
    logic           hdr_bad_s;

    // s_ready_q mirrors the state, so it doubles as the acceptance qualifier.
    assign hs_s      = s_valid && s_ready_q;
    assign hdr_n_s   = s_data[15:0];
    assign hdr_l_s   = s_data[31:16];
    assign hdr_bad_s = (hdr_n_s == 16'd0) ||
                       (({1'b0, hdr_l_s} + {1'b0, hdr_n_s}) > MEM_SIZE);

    // Next-state, counter and output computation.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        l_d       = l_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HEADER;
                    error_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            HEADER: begin
                if (hs_s) begin
                    if (hdr_bad_s) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        f_d     = {FW{1'b0}};
                        l_d     = hdr_l_s;
                        rem_d   = hdr_n_s;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = {W{1'b0}};
`endif
                    end
                end else begin
                    state_d = HEADER;
                end
            end

            LOAD: begin
                if (hs_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = make_addr(l_q, f_q);
                    wr_data_d = s_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ s_data;
`endif
                    if (f_q == FIELD_LAST) begin
                        f_d   = {FW{1'b0}};
                        l_d   = l_q + 16'd1;
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        f_d = f_q + FW'(1'b1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (hs_s) begin
                    if (s_data != csum_q) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    state_d = DONE;
                end else begin
                    state_d = CHECK;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so that they line up
        // with the state they describe; done is registered from the current
        // state and therefore appears in the cycle after DONE.
        s_ready_d = (state_d == HEADER) || (state_d == LOAD) || (state_d == CHECK);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DONE);
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            f_q       <= {FW{1'b0}};
            l_q       <= 16'd0;
            rem_q     <= 16'd0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {W{1'b0}};
            wr_data_q <= {W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= {W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            l_q       <= l_d;
            rem_q     <= rem_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign s_ready        = s_ready_q;
    assign wr_en_ext_im   = wr_en_q;
    assign wr_addr_ext_im = wr_addr_q;
    assign wr_data_ext_im = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule
